// File: rtl/inst_cache_if.sv
// Refill port between the instruction cache and the slower instruction memory.
//
// Handshake: the cache raises mem_req_o with a stable word-aligned mem_addr_o
// and holds both until the memory answers. The memory answers with a
// single-cycle mem_ack_i pulse, and mem_data_i is valid in that same cycle.
// mem_req_o drops on the following cycle. An ack with no request outstanding
// is ignored.
interface inst_cache_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  // Cache side: issues requests and consumes the refill data.
  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  // Memory side: answers requests.
  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only, one-word-per-line instruction cache.
//
// A hit returns the instruction combinationally, so the fetch stage sees a
// zero-wait ROM. A miss raises stall_o and refills one word over the memory
// port. When the refill completes, the cache returns to IDLE, and the held
// fetch address then hits.
module inst_cache #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic [31:0]        addr_i,
  output logic [31:0]        inst_o,
  output logic               stall_o,
  input  logic               flush_i,
  inst_cache_if.master       mem,
  output logic [31:0]        miss_count_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        miss_count_q, miss_count_d;
  logic               mem_req;

  // The tag and data arrays are qualified by valid_q, so they need no reset.
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               hit_idle;
  logic               fill_we;

  assign idx      = addr_i[IDX_W+1:2];
  assign tag      = addr_i[31:IDX_W+2];
  // The refill always targets the address latched at miss start,
  // not whatever the core is presenting now.
  assign fill_idx = mem_addr_q[IDX_W+1:2];
  assign fill_tag = mem_addr_q[31:IDX_W+2];

  assign hit      = ce_i & valid_q[idx] & (tag_mem[idx] == tag);
  // During a refill, even a lookup that matches another line is held off.
  // This keeps the core in lockstep with the single outstanding miss.
  assign hit_idle = hit & (state_q == IDLE);
  assign fill_we  = (state_q == REQ) & mem.mem_ack_i;

  assign inst_o       = hit_idle ? data_mem[idx] : 32'h0;
  assign stall_o      = ce_i & ~hit_idle;
  assign mem.mem_req_o  = mem_req;
  assign mem.mem_addr_o = mem_addr_q;
  assign miss_count_o = miss_count_q;

  // Next-state, refill request and valid-bit bookkeeping.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_addr_d   = mem_addr_q;
    miss_count_d = miss_count_q;
    mem_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush in the same cycle postpones the miss; the lookup retries next cycle.
        if (ce_i & ~hit & ~flush_i) begin
          state_d      = REQ;
          mem_addr_d   = {addr_i[31:2], 2'b00};
          miss_count_d = miss_count_q + 32'd1;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem.mem_ack_i) begin
          state_d = IDLE;
          if (!flush_i) begin
            valid_d[fill_idx] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over a refill landing in the same cycle.
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mem_addr_q   <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_addr_q   <= mem_addr_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Line storage is written only when a refill completes.
  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem.mem_data_i;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Testbench for inst_cache. It runs directed fetch scenarios and then a
// randomized phase. A line-level cache model checks every output every cycle.
module tb_inst_cache;
  localparam int LINES = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        stall_o;
  logic        flush_i;
  logic [31:0] miss_count_o;

  inst_cache_if mif();

  inst_cache #(.LINES(LINES)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .addr_i       (addr_i),
    .inst_o       (inst_o),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .mem          (mif),
    .miss_count_o (miss_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model describes each line as "which word address it holds, and what
  // data it holds". A refill in flight is a single pending word address.
  bit          m_valid [LINES];
  logic [29:0] m_waddr [LINES];
  logic [31:0] m_data  [LINES];
  bit          m_busy;
  logic [31:0] m_lat;
  logic [31:0] m_count;
  bit          model_ok = 1'b0;

  // Backing instruction memory contents; word 0 holds 0x34011100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h34011100;
  endfunction

  // ---------------- memory responder controls ----------------
  int          ack_delay_cfg = 0;   // REQ cycles before ack; -1 = random
  int          ack_wait      = 0;
  int          spurious_pct  = 0;
  bit          force_ack     = 1'b0;
  bit          use_override  = 1'b0;
  logic [31:0] override_data = 32'h0;

  // Observations from the most recent step
  logic        obs_stall;
  logic        obs_req;
  logic [31:0] obs_inst;
  logic [31:0] obs_count;

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit r, input bit ce, input logic [31:0] a, input bit fl);
    logic [3:0] ix;
    bit         hit;
    bit         hit_idle;
    bit         ack_now;
    logic [31:0] dat;
    @(negedge clk);
    rst     = r;
    ce_i    = ce;
    addr_i  = a;
    flush_i = fl;
    ack_now = 1'b0;
    dat     = $urandom;
    if (force_ack) begin
      ack_now   = 1'b1;
      force_ack = 1'b0;
    end else if (m_busy) begin
      if (ack_wait == 0) begin
        ack_now = 1'b1;
        dat     = use_override ? override_data : mem_word(m_lat);
      end else begin
        ack_wait--;
      end
    end else begin
      ack_now = ($urandom_range(0, 99) < spurious_pct);
    end
    mif.mem_ack_i  = ack_now;
    mif.mem_data_i = dat;
    #1;
    ix       = a[5:2];
    hit      = ce && m_valid[ix] && (m_waddr[ix] == a[31:2]);
    hit_idle = hit && !m_busy;
    obs_stall = stall_o;
    obs_req   = mif.mem_req_o;
    obs_inst  = inst_o;
    obs_count = miss_count_o;
    if (model_ok) begin
      check_eq("inst_o", inst_o, hit_idle ? m_data[ix] : 32'h0);
      check_eq("stall_o", {31'h0, stall_o}, {31'h0, ce && !hit_idle});
      check_eq("mem_req_o", {31'h0, mif.mem_req_o}, {31'h0, m_busy});
      check_eq("mem_addr_o", mif.mem_addr_o, m_lat);
      check_eq("miss_count_o", miss_count_o, m_count);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_busy   = 1'b0;
      m_lat    = 32'h0;
      m_count  = 32'h0;
      model_ok = 1'b1;
    end else begin
      if (m_busy) begin
        if (ack_now) begin
          m_waddr[m_lat[5:2]] = m_lat[31:2];
          m_data[m_lat[5:2]]  = dat;
          m_valid[m_lat[5:2]] = !fl;
          m_busy = 1'b0;
        end
      end else if (ce && !hit && !fl) begin
        m_busy   = 1'b1;
        m_lat    = {a[31:2], 2'b00};
        m_count  = m_count + 32'd1;
        ack_wait = (ack_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ack_delay_cfg;
      end
      if (fl) begin
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      end
    end
  endtask

  // Fetch one address until it is delivered; returns number of stalled cycles.
  task automatic fetch(input logic [31:0] a, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1'b0, 1'b1, a, 1'b0);
      if (obs_stall) stalls++;
      else done = 1'b1;
    end
    check_eq("fetch_completes", {31'h0, done}, 32'h1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    logic [31:0] a;
    rst            = 1'b1;
    ce_i           = 1'b0;
    addr_i         = 32'h0;
    flush_i        = 1'b0;
    mif.mem_ack_i  = 1'b0;
    mif.mem_data_i = 32'h0;

    // Reset state
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("reset_count", obs_count, 32'h0);
    check_eq("reset_req", {31'h0, obs_req}, 32'h0);

    // Cold miss at 0: ack on cycle 3 -> 4 stalled cycles, then hit
    ack_delay_cfg = 2;
    fetch(32'h0000_0000, n);
    check_eq("cold_miss_stalls", 32'(n), 32'd4);
    check_eq("cold_miss_inst", obs_inst, 32'h3401_1100);
    check_eq("cold_miss_count", obs_count, 32'd1);

    // Re-fetch is a same-cycle hit
    step(1'b0, 1'b1, 32'h0000_0000, 1'b0);
    check_eq("refetch_stall", {31'h0, obs_stall}, 32'h0);
    check_eq("refetch_req", {31'h0, obs_req}, 32'h0);
    check_eq("refetch_inst", obs_inst, 32'h3401_1100);
    check_eq("refetch_count", obs_count, 32'd1);

    // Conflict on index 1
    do_reset();
    ack_delay_cfg = 0;
    fetch(32'h0000_0004, n);
    check_eq("fill4_stalls", 32'(n), 32'd2);
    fetch(32'h0000_0044, n);
    check_eq("conflict_stalls", 32'(n), 32'd2);
    fetch(32'h0000_0004, n);
    check_eq("conflict_refill_stalls", 32'(n), 32'd2);
    check_eq("conflict_count", obs_count, 32'd3);

    // Flush during REQ, including the ack cycle: the line must stay invalid
    ack_delay_cfg = 1;
    use_override  = 1'b1;
    override_data = 32'hDEAD_BEEF;
    step(1'b0, 1'b1, 32'h0000_0008, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0008, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0008, 1'b1);
    use_override = 1'b0;
    step(1'b0, 1'b1, 32'h0000_0008, 1'b0);
    check_eq("flush_refetch_stall", {31'h0, obs_stall}, 32'h1);
    step(1'b0, 1'b1, 32'h0000_0008, 1'b0);
    check_eq("flush_refetch_req", {31'h0, obs_req}, 32'h1);
    fetch(32'h0000_0008, n);

    // Reset mid-REQ, late ack ignored
    ack_delay_cfg = 5;
    step(1'b0, 1'b1, 32'h0000_0010, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0010, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0010, 1'b0);
    force_ack = 1'b1;
    step(1'b0, 1'b0, 32'h0000_0010, 1'b0);
    check_eq("rst_mid_req", {31'h0, obs_req}, 32'h0);
    check_eq("rst_mid_stall", {31'h0, obs_stall}, 32'h0);
    check_eq("rst_mid_count", obs_count, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0010, 1'b0);
    check_eq("rst_mid_refetch_stall", {31'h0, obs_stall}, 32'h1);
    ack_delay_cfg = 0;
    fetch(32'h0000_0010, n);

    // ce_i low: no output, no stall, no request, even at a cached address
    for (int k = 0; k < 6; k++) begin
      a = (k == 0) ? 32'h0000_0010 : $urandom;
      step(1'b0, 1'b0, a, 1'b0);
      check_eq("ce_off_inst", obs_inst, 32'h0);
      check_eq("ce_off_stall", {31'h0, obs_stall}, 32'h0);
    end

    // Randomized phase
    ack_delay_cfg = -1;
    spurious_pct  = 10;
    a = 32'h0;
    for (int k = 0; k < 3000; k++) begin
      if (!obs_stall || $urandom_range(0, 99) < 30) begin
        a = ({30'h0, 2'($urandom_range(0, 3))} << 6) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 85, a,
           $urandom_range(0, 99) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
